// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtract sequencer.
package serial_sub_pkg;

  // Sequencer states; the unused encoding 2'd3 falls back to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Requester-side bus of the bit-serial subtract sequencer.
//
// Handshake: the requester raises start with a/b/bin valid; the sequencer
// accepts it only on an edge where it is idle (busy=0), after which a/b/bin
// may change freely. start while busy is ignored, never queued. done is a
// one-cycle pulse marking diff/bout valid; they hold until the next result.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  import serial_sub_pkg::*;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  state_t           dbg_state;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, dbg_state
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, dbg_state
  );

endinterface

// File: rtl/full_sub_decoder.sv
// One-bit full subtractor cell: d = a - b - c, br = borrow out.
module full_sub_decoder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d,
  output logic br
);

  assign d  = a ^ b ^ c;
  assign br = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Runs a single full-subtractor cell LSB-first over WIDTH cycles to compute
// diff = a - b - bin, with a start/done handshake toward the requester.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_sub_ctrl_if.slave bus
);

  // Extra counter bit keeps WIDTH=1 legal (single RUN cycle, cnt stays 0).
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             shift_en;
  logic             load_out;
  logic             busy_c;
  logic             cell_d;
  logic             cell_br;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  // Cell sees only registered bits, so its path is one gate deep.
  full_sub_decoder u_cell (
    .a  (sa[0]),
    .b  (sb[0]),
    .c  (brw),
    .d  (cell_d),
    .br (cell_br)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state: IDLE -> RUN on start, RUN for WIDTH edges, DONE for one.
  always_comb begin
    state_nx = S_IDLE;
    case (state)
      S_IDLE:  state_nx = bus.start ? S_RUN : S_IDLE;
      S_RUN:   state_nx = (cnt == LAST) ? S_DONE : S_RUN;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Decoded controls for the datapath and the busy flag.
  always_comb begin
    accept   = 1'b0;
    shift_en = 1'b0;
    load_out = 1'b0;
    busy_c   = 1'b1;
    case (state)
      S_IDLE: begin
        accept = bus.start;
        busy_c = 1'b0;
      end
      S_RUN:   shift_en = 1'b1;
      S_DONE:  load_out = 1'b1;
      default: busy_c   = 1'b1;
    endcase
  end

  // Operand capture and per-bit shifting; result bits enter at the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa  <= '0;
      sb  <= '0;
      sr  <= '0;
      brw <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      sa  <= bus.a;
      sb  <= bus.b;
      brw <= bus.bin;
      cnt <= '0;
    end else if (shift_en) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= (sr >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
      brw <= cell_br;
      cnt <= cnt + CW'(1);
    end
  end

  // Registered outputs: one-cycle done, result held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      done_q <= load_out;
      if (load_out) begin
        diff_q <= sr;
        bout_q <= brw;
      end
    end
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl: WIDTH=8 and WIDTH=1 instances.
module tb_serial_sub_ctrl;
  import serial_sub_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [31:0] exp_q[$];

  serial_sub_ctrl_if #(.WIDTH(8)) s8 ();
  serial_sub_ctrl_if #(.WIDTH(1)) s1 ();

  serial_sub_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(s8));
  serial_sub_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(s1));

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation; expv = {bout, diff}. Returns observed bout.
  task automatic op8(input string tag, input logic [7:0] va, input logic [7:0] vb,
                     input logic vbin, input logic [8:0] expv, output logic obout);
    int n;
    bit got;
    logic [31:0] e;
    exp_q.push_back(32'(expv));
    @(negedge clk);
    s8.a = va; s8.b = vb; s8.bin = vbin; s8.start = 1'b1;
    @(negedge clk);
    s8.start = 1'b0;
    s8.a = 8'($urandom_range(0, 255));
    s8.b = 8'($urandom_range(0, 255));
    s8.bin = 1'($urandom_range(0, 1));
    n = 0; got = 0;
    while (!got && n < 30) begin
      @(negedge clk);
      n++;
      if (n == 1) check_val({tag, "_busy"}, 32'(s8.busy), 32'd1);
      if (s8.done) got = 1;
    end
    check_val({tag, "_lat"}, 32'(n), 32'd9);
    e = exp_q.pop_front();
    check_val({tag, "_diff"}, 32'(s8.diff), 32'(e[7:0]));
    check_val({tag, "_bout"}, 32'(s8.bout), 32'(e[8]));
    obout = s8.bout;
    @(negedge clk);
    check_val({tag, "_pulse"}, 32'(s8.done), 32'd0);
  endtask

  // One WIDTH=1 operation; expv = {br, d}.
  task automatic op1(input string tag, input logic va, input logic vb,
                     input logic vc, input logic [1:0] expv);
    int n;
    bit got;
    @(negedge clk);
    s1.a = va; s1.b = vb; s1.bin = vc; s1.start = 1'b1;
    @(negedge clk);
    s1.start = 1'b0;
    n = 0; got = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (s1.done) got = 1;
    end
    check_val({tag, "_lat"}, 32'(n), 32'd2);
    check_val({tag, "_res"}, {30'd0, s1.bout, s1.diff}, 32'(expv));
  endtask

  logic [7:0] vec_a    [7] = '{8'h05, 8'h03, 8'hFF, 8'h00, 8'h80, 8'h00, 8'hA5};
  logic [7:0] vec_b    [7] = '{8'h03, 8'h05, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h5A};
  logic       vec_bin  [7] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
  logic [8:0] vec_exp  [7] = '{9'h002, 9'h1FE, 9'h1FF, 9'h000, 9'h07F, 9'h1FF, 9'h04B};
  // Full-subtractor truth table indexed by {a,b,c}: {br,d}.
  logic [1:0] tt [8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};

  initial begin
    logic bo;
    logic [7:0] lo;
    int ndone, first_i, second_i;
    n_checks = 0;
    n_errors = 0;
    s8.start = 0; s8.a = 0; s8.b = 0; s8.bin = 0;
    s1.start = 0; s1.a = 0; s1.b = 0; s1.bin = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(s8.busy), 32'd0);
    check_val("rst_done", 32'(s8.done), 32'd0);
    check_val("rst_diff", 32'(s8.diff), 32'd0);
    check_val("rst_bout", 32'(s8.bout), 32'd0);
    check_val("rst_state", 32'(s8.dbg_state), 32'(S_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 7; i++)
      op8($sformatf("vec%0d", i), vec_a[i], vec_b[i], vec_bin[i], vec_exp[i], bo);

    // Chained 16-bit: 0x1234 - 0x0235 = 0x0FFF via bout -> bin.
    op8("chain_lo", 8'h34, 8'h35, 1'b0, 9'h1FF, bo);
    lo = s8.diff;
    op8("chain_hi", 8'h12, 8'h02, bo, 9'h00F, bo);
    check_val("chain_16", {16'd0, s8.diff, lo}, 32'h0000_0FFF);

    // start held high: accepts only from IDLE, one done per accept.
    @(negedge clk);
    s8.a = 8'h10; s8.b = 8'h01; s8.bin = 1'b0; s8.start = 1'b1;
    ndone = 0; first_i = -1; second_i = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s8.done) begin
        ndone++;
        if (first_i < 0) first_i = i; else second_i = i;
      end
    end
    s8.start = 1'b0;
    check_val("hold_ndone", 32'(ndone), 32'd2);
    check_val("hold_first", 32'(first_i), 32'd9);
    check_val("hold_second", 32'(second_i), 32'd19);
    check_val("hold_diff", 32'(s8.diff), 32'h0F);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (s8.done) ndone++;
    end
    check_val("hold_quiet", 32'(ndone), 32'd0);
    check_val("hold_idle", 32'(s8.busy), 32'd0);

    // Reset in the middle of RUN at cnt=3.
    @(negedge clk);
    s8.a = 8'h05; s8.b = 8'h03; s8.bin = 1'b0; s8.start = 1'b1;
    @(negedge clk);
    s8.start = 1'b0;
    repeat (3) @(negedge clk);
    check_val("mid_state", 32'(s8.dbg_state), 32'(S_RUN));
    rst = 1'b1;
    #1;
    check_val("mid_busy", 32'(s8.busy), 32'd0);
    check_val("mid_diff", 32'(s8.diff), 32'd0);
    check_val("mid_state0", 32'(s8.dbg_state), 32'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (s8.done) ndone++;
    end
    check_val("mid_nodone", 32'(ndone), 32'd0);
    op8("post_rst", 8'hC8, 8'h37, 1'b0, 9'h091, bo);

    // WIDTH=1 truth table.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      op1($sformatf("w1_%0d", i), abc[2], abc[1], abc[0], tt[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
